life_pattern_loader: RTL and testbench

LIFE_PATTERN_LOADER -- requirements
Module: life_pattern_loader

---
 rtl/life_pattern_loader.sv | 130 +++++++++++++
 tb/tb_life_pattern_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_pattern_loader.sv
// Purpose: parses an ASCII Life pattern ('#' live, '.' dead, '\n' next row) into a flat grid bitmap.
// Latency: one character per cycle; done/load_pulse/error are registered on the accepting edge of the final or faulty character.
// Backpressure: in_ready is high only while loading; it is a pure function of registered state, never of in_valid.
module life_pattern_loader #(
    parameter int WIDTH  = 20,
    parameter int HEIGHT = 20
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               in_valid,
    input  logic [7:0]                         in_data,
    input  logic                               in_last,
    output logic                               in_ready,
    output logic [WIDTH*HEIGHT-1:0]            init,
    output logic                               busy,
    output logic                               done,
    output logic                               load_pulse,
    output logic                               error,
    output logic [1:0]                         err_code,
    output logic [$clog2(HEIGHT+1)-1:0]        err_row,
    output logic [$clog2(WIDTH+1)-1:0]         err_col
);

    localparam int CELL_NUM = WIDTH * HEIGHT;
    localparam int RW       = $clog2(HEIGHT + 1);
    localparam int CW       = $clog2(WIDTH + 1);
    localparam int IW       = (CELL_NUM > 1) ? $clog2(CELL_NUM) : 1;

    localparam logic [RW-1:0] ROW_FULL = RW'(HEIGHT);
    localparam logic [CW-1:0] COL_FULL = CW'(WIDTH);

    localparam logic [7:0] CH_SET  = 8'h23;  // '#'
    localparam logic [7:0] CH_CLR  = 8'h2E;  // '.'
    localparam logic [7:0] CH_NL   = 8'h0A;  // '\n'

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CHAR = 2'd1;
    localparam logic [1:0] ERR_COL  = 2'd2;
    localparam logic [1:0] ERR_ROW  = 2'd3;

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

    state_t          state;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic [IW-1:0]   idx;
    logic            is_cell;
    logic [1:0]      fault;

    // Classify the presented character and decide whether it would abort the load.
    // Row overflow is checked before column overflow so a full grid reports the row.
    always_comb begin
        idx     = IW'(row) * IW'(WIDTH) + IW'(col);
        is_cell = (in_data == CH_SET) || (in_data == CH_CLR);
        fault   = ERR_NONE;
        if (is_cell) begin
            if (row == ROW_FULL) begin
                fault = ERR_ROW;
            end else if (col == COL_FULL) begin
                fault = ERR_COL;
            end
        end else if (in_data != CH_NL) begin
            fault = ERR_CHAR;
        end
    end

    // Load state machine: all outputs are registered here; start restarts from any state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            init       <= '0;
            row        <= '0;
            col        <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_pulse <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
            err_row    <= '0;
            err_col    <= '0;
        end else begin
            load_pulse <= 1'b0;
            if (start) begin
                state    <= LOAD;
                init     <= '0;
                row      <= '0;
                col      <= '0;
                in_ready <= 1'b1;
                busy     <= 1'b1;
                done     <= 1'b0;
                error    <= 1'b0;
                err_code <= ERR_NONE;
                err_row  <= '0;
                err_col  <= '0;
            end else if (state == LOAD && in_valid) begin
                if (fault != ERR_NONE) begin
                    // Abort: keep bits already written, record where it went wrong.
                    state    <= ERR;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    error    <= 1'b1;
                    err_code <= fault;
                    err_row  <= row;
                    err_col  <= col;
                end else begin
                    if (is_cell) begin
                        if (in_data == CH_SET) begin
                            init[idx] <= 1'b1;
                        end
                        col <= col + CW'(1);
                    end else begin
                        // Newline: saturate so extra blank lines are harmless.
                        row <= (row == ROW_FULL) ? row : row + RW'(1);
                        col <= '0;
                    end
                    if (in_last) begin
                        state      <= DONE;
                        in_ready   <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        load_pulse <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_life_pattern_loader.sv
// Bench for life_pattern_loader: table of patterns with a scoreboard of expected outcomes,
// plus hand-written sequences for restart, reset mid-load and idle behaviour.
module tb_life_pattern_loader;

    localparam int W  = 20;
    localparam int H  = 20;
    localparam int N  = W * H;
    localparam int RW = $clog2(H + 1);
    localparam int CW = $clog2(W + 1);
    localparam int NV = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_last;
    logic          in_ready;
    logic [N-1:0]  init;
    logic          busy;
    logic          done;
    logic          load_pulse;
    logic          error;
    logic [1:0]    err_code;
    logic [RW-1:0] err_row;
    logic [CW-1:0] err_col;

    life_pattern_loader #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .init       (init),
        .busy       (busy),
        .done       (done),
        .load_pulse (load_pulse),
        .error      (error),
        .err_code   (err_code),
        .err_row    (err_row),
        .err_col    (err_col)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [255:0] text;
        int           len;
        bit           rnd;
    } vec_t;

    typedef struct {
        bit            done;
        bit            err;
        logic [1:0]    code;
        logic [RW-1:0] erow;
        logic [CW-1:0] ecol;
        logic [N-1:0]  init;
    } exp_t;

    vec_t tbl [NV];
    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pulse_cnt = 0;

    // Count every cycle load_pulse is seen high.
    always @(negedge clock) begin
        if (load_pulse) pulse_cnt = pulse_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] app(input logic [255:0] t, input logic [7:0] c);
        return {t[247:0], c};
    endfunction

    // Reference behaviour of one complete load ending with in_last on the final character.
    function automatic exp_t model(input logic [255:0] t, input int len);
        exp_t e;
        int r, c;
        logic [7:0] ch;
        e.done = 1'b0; e.err = 1'b0; e.code = 2'd0; e.erow = '0; e.ecol = '0; e.init = '0;
        r = 0; c = 0;
        for (int i = 0; i < len; i++) begin
            ch = t[8*(len-1-i) +: 8];
            if (ch == 8'h23 || ch == 8'h2E) begin
                if (r == H || c == W) begin
                    e.err = 1'b1; e.code = (r == H) ? 2'd3 : 2'd2;
                    e.erow = RW'(r); e.ecol = CW'(c);
                    return e;
                end
                if (ch == 8'h23) e.init[r*W + c] = 1'b1;
                c = c + 1;
            end else if (ch == 8'h0A) begin
                if (r < H) r = r + 1;
                c = 0;
            end else begin
                e.err = 1'b1; e.code = 2'd1; e.erow = RW'(r); e.ecol = CW'(c);
                return e;
            end
        end
        e.done = 1'b1;
        return e;
    endfunction

    task automatic do_start();
        @(negedge clock);
        start = 1'b1; in_valid = 1'b1; in_data = 8'h23; in_last = 1'b0;
        @(negedge clock);
        start = 1'b0; in_valid = 1'b0;
    endtask

    // Stream characters from a negedge; returns the number of cycles spent.
    task automatic feed(input logic [255:0] t, input int len, input bit rnd, input bit last_at_end,
                        output int cycles);
        int idx;
        idx = 0; cycles = 0;
        while (idx < len && cycles < 500) begin
            if (!in_ready) break;
            in_data  = t[8*(len-1-idx) +: 8];
            in_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_last  = in_valid ? (last_at_end && idx == len - 1) : ($urandom_range(0, 1) == 1);
            @(posedge clock);
            if (in_valid) idx++;
            cycles++;
            @(negedge clock);
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int w;
        w = 0;
        while (!(done || error) && w < 10) begin
            @(negedge clock);
            w++;
        end
        if (!(done || error)) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: done=%0b error=%0b required one of them high", name, done, error);
        end
    endtask

    initial begin
        logic [N-1:0] glider;
        logic [255:0] t;
        exp_t e;
        int p0, cyc;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;

        // Pattern table.
        tbl[0].text = ".#.\n..#\n###\n";  tbl[0].len = 12; tbl[0].rnd = 1'b0;
        tbl[1].text = ".#.\n..#\n###\n";  tbl[1].len = 12; tbl[1].rnd = 1'b1;
        tbl[2].text = "#x";                tbl[2].len = 2;  tbl[2].rnd = 1'b0;
        t = '0; for (int k = 0; k < 21; k++) t = app(t, 8'h2E);
        tbl[3].text = t;                   tbl[3].len = 21; tbl[3].rnd = 1'b0;
        t = '0; for (int k = 0; k < 21; k++) t = app(t, 8'h0A); t = app(t, 8'h23);
        tbl[4].text = t;                   tbl[4].len = 22; tbl[4].rnd = 1'b1;
        tbl[5].text = "\n";                tbl[5].len = 1;  tbl[5].rnd = 1'b0;
        tbl[6].text = "#..#\n\n#";         tbl[6].len = 7;  tbl[6].rnd = 1'b1;
        t = '0; for (int k = 0; k < 20; k++) t = app(t, 8'h23); t = app(t, 8'h0A); t = app(t, 8'h23);
        tbl[7].text = t;                   tbl[7].len = 22; tbl[7].rnd = 1'b0;

        glider = '0;
        glider[1] = 1'b1; glider[22] = 1'b1; glider[40] = 1'b1; glider[41] = 1'b1; glider[42] = 1'b1;

        // Reset state.
        repeat (3) @(negedge clock);
        check("rst init", init, '0);
        check("rst in_ready", N'(in_ready), N'(0));
        check("rst busy", N'(busy), N'(0));
        check("rst done", N'(done), N'(0));
        check("rst error", N'(error), N'(0));
        check("rst err_code", N'(err_code), N'(0));
        reset = 1'b0;

        // Idle ignores characters.
        in_valid = 1'b1; in_data = 8'h23; in_last = 1'b1;
        repeat (3) @(negedge clock);
        in_valid = 1'b0; in_last = 1'b0;
        check("idle init", init, '0);
        check("idle in_ready", N'(in_ready), N'(0));
        check("idle done", N'(done), N'(0));

        for (int i = 0; i < NV; i++) begin
            p0 = pulse_cnt;
            do_start();
            check($sformatf("case%0d busy", i), N'(busy), N'(1));
            sb.push_back(model(tbl[i].text, tbl[i].len));
            feed(tbl[i].text, tbl[i].len, tbl[i].rnd, 1'b1, cyc);
            wait_end($sformatf("case%0d", i));
            repeat (3) @(negedge clock);
            e = sb.pop_front();
            check($sformatf("case%0d done", i), N'(done), N'(e.done));
            check($sformatf("case%0d error", i), N'(error), N'(e.err));
            check($sformatf("case%0d err_code", i), N'(err_code), N'(e.code));
            check($sformatf("case%0d err_row", i), N'(err_row), N'(e.erow));
            check($sformatf("case%0d err_col", i), N'(err_col), N'(e.ecol));
            check($sformatf("case%0d init", i), init, e.init);
            check($sformatf("case%0d pulses", i), N'(pulse_cnt - p0), N'(e.done ? 1 : 0));
            check($sformatf("case%0d busy after", i), N'(busy), N'(0));
            if (i < 2) check($sformatf("case%0d glider", i), init, glider);
            if (i == 0) check("glider cycles", N'(cyc), N'(12));
        end

        // Restart in the middle of a load.
        p0 = pulse_cnt;
        do_start();
        t = "#####";
        feed(t, 5, 1'b0, 1'b0, cyc);
        check("restart mid busy", N'(busy), N'(1));
        check("restart mid done", N'(done), N'(0));
        do_start();
        check("restart cleared init", init, '0);
        t = "#\n";
        feed(t, 2, 1'b0, 1'b1, cyc);
        wait_end("restart");
        repeat (2) @(negedge clock);
        check("restart init", init, N'(1));
        check("restart done", N'(done), N'(1));
        check("restart pulses", N'(pulse_cnt - p0), N'(1));

        // Reset in the middle of a load.
        p0 = pulse_cnt;
        do_start();
        t = "##";
        feed(t, 2, 1'b0, 1'b0, cyc);
        check("pre-reset init", init, N'(3));
        reset = 1'b1; start = 1'b1;
        @(posedge clock);
        #1;
        check("mid rst init", init, '0);
        check("mid rst in_ready", N'(in_ready), N'(0));
        check("mid rst busy", N'(busy), N'(0));
        check("mid rst done", N'(done), N'(0));
        check("mid rst error", N'(error), N'(0));
        check("mid rst err_row", N'(err_row), N'(0));
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        in_valid = 1'b1; in_data = 8'h0A; in_last = 1'b1;
        repeat (4) @(negedge clock);
        in_valid = 1'b0; in_last = 1'b0;
        check("post rst pulses", N'(pulse_cnt - p0), N'(0));
        check("post rst in_ready", N'(in_ready), N'(0));
        check("post rst done", N'(done), N'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
